instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit: the initiator side of the instruction memory read port. It owns the PC and issues word reads to `instruction_mem`, which has one-cycle registered read latency. It buffers returned words in a 2-entry queue and hands {pc, instr} to decode over a valid/ready handshake. It also handles redirects from execute (branch/jump) and address faults.

## Interface
Parameters:
- `RESET_PC`, default 32'h0100_0000: byte PC fetched first after reset.
- `IMEM_BASE`, default 32'h0100_0000: lowest legal byte address.
- `IMEM_LIMIT`, default 32'h0100_07FF: highest legal byte address.

Ports:
- `clk`  in  1: the single clock. All state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `imem_rd`  out  1: read strobe to instruction memory.
- `imem_addr`  out  32: word address, {2'b00, pc[31:2]}.
- `imem_instr`  in  32: read data. Valid the cycle after `imem_rd`=1.
- `if_valid`  out  1: {`if_pc`, `if_instr`, `if_fault`} valid to decode.
- `if_ready`  in  1: decode accepts the current entry.
- `if_pc`  out  32: byte PC of the presented entry.
- `if_instr`  out  32: instruction word. 32'h0000_0013 (NOP) when `if_fault`=1.
- `if_fault`  out  1: the presented entry is a fetch fault.
- `redirect_valid`  in  1: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32: byte target of the redirect.

## Operation
- Registers: `pc` (next byte address to issue), a 2-entry FIFO of {pc, instr, fault}, an `inflight` bit and pc tag for the outstanding read, and a `kill` bit.
- States:
  - RUN: normal fetching.
  - DRAIN: fault detected; waiting for the FIFO and any read in flight to empty.
  - HALT: fault entry queued or presented; no reads issued.
- Issue condition in RUN: `count + inflight - pop < 2` and `pc` is legal. Here `pop` = `if_valid & if_ready`. On issue, `imem_rd`=1, `inflight` is set and `pc` advances by 4.
- An address is legal when `pc[1:0]==0` and `IMEM_BASE <= pc <= IMEM_LIMIT-3`.
- Illegal `pc` in RUN: do not issue; go to DRAIN. When `count==0` and `inflight==0`, push the fault entry {pc, NOP, 1} and go to HALT. HALT is left only by a redirect.
- Response: in the cycle after an issue, push {tag, `imem_instr`, 0} into the FIFO unless `kill` is set. The response is dropped if `kill`=1. `inflight` clears either way.
- Redirect (highest priority, accepted in any state):
  - flush the FIFO;
  - set `kill` if a read is in flight;
  - load `pc` with `redirect_pc`;
  - go to RUN.
- `if_valid` = FIFO non-empty & !`redirect_valid`. No transfer occurs in a redirect cycle.
- FIFO push and pop in the same cycle are both honoured. Push into a full FIFO cannot occur because the issue rule prevents it; the bench asserts this never happens.
- Sequential wrap: fetching past `IMEM_LIMIT` produces a fault at pc 32'h0100_0800. The PC never wraps back into the memory.

## Timing
- Reset values: `imem_rd`=0, `imem_addr`=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `if_fault`=0. Also `pc`=`RESET_PC`, FIFO empty, `inflight`=0, `kill`=0, state RUN.
- Startup: first cycle with `rst`=0 is C0, with `imem_rd`=1 and addr `RESET_PC`>>2. The response is captured at the end of C1. `if_valid`=1 in C2.
- Steady state with `if_ready` held at 1: one instruction per cycle and one read per cycle.
- Redirect latency: `redirect_valid` in cycle N gives the target issued in N+1 and `if_valid` in N+3.
- `rst` asserted mid-operation: all state returns to reset values at the next edge. A response arriving after reset is ignored (`inflight` cleared).
- Outputs `if_*` come straight from the FIFO head register. `imem_rd` and `imem_addr` are combinational from state, `count`, `inflight` and `if_ready`.

## Structure
- Add `IMEM_BASE`, `IMEM_LIMIT`, `RESET_PC` and `NOP_INSTR` (32'h0000_0013) to `defines.vh`. Parameters default to these values.
- Add state encodings `IF_RUN`, `IF_DRAIN` and `IF_HALT` to `defines.vh`.
- One sub-module, `fetch_fifo`: 2-entry, 65-bit wide, synchronous flush, simultaneous push/pop, `count` output.

## Test plan
- Reset release with `if_ready`=1 and memory preloaded: `if_pc` sequence 0x0100_0000, 0x0100_0004, 0x0100_0008, ... on consecutive cycles from C2. `if_instr` matches memory and `if_fault`=0.
- `if_ready`=0 for 5 cycles in mid-stream: at most 2 entries buffered, `imem_rd` drops, nothing lost or duplicated. Stream resumes in order when `if_ready` returns to 1.
- `redirect_valid` with `redirect_pc`=0x0100_0100 while a read is in flight: the stale response is discarded. The next accepted `if_pc` is 0x0100_0100, 3 cycles after the redirect.
- Redirect to 0x0100_0102 (misaligned): no `imem_rd`. One entry is presented with `if_fault`=1, `if_pc`=0x0100_0102, `if_instr`=0x13. No further entries until the next redirect.
- Redirect to 0x0100_07F8 and run sequentially: entries for 0x0100_07F8 and 0x0100_07FC, then a fault entry with `if_pc`=0x0100_0800.
- `rst` pulsed for 1 cycle mid-stream: all outputs return to reset values. Fetch restarts at 0x0100_0000 with `if_valid` two cycles after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - default memory window and reset PC
//   - NOP encoding used for fault entries
//   - fetch FSM state encoding
//   - 65-bit FIFO entry layout {pc, instr, fault}
//   - address legality helper
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

   localparam logic [31:0] DEF_IMEM_BASE  = 32'h0100_0000;
   localparam logic [31:0] DEF_IMEM_LIMIT = 32'h0100_07FF;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0100_0000;
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

   typedef enum logic [1:0] {
      IF_RUN   = 2'd0,
      IF_DRAIN = 2'd1,
      IF_HALT  = 2'd2
   } if_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        fault;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   // A fetch address is usable when it is word aligned and the whole word
   // lies inside [base, limit].
   function automatic logic addr_legal(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
      return (pc[1:0] == 2'b00) && (pc >= base) && (pc <= (limit - 32'd3));
   endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Two-entry queue of fetch entries between the memory response path and
// decode. Slot 0 is always the head, so the head fields can drive decode
// directly from flops.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   flush         : synchronous empty (wins over push/pop)
//   push, push_entry : write one entry at the tail
//   pop           : consume the head entry
//   head          : current head entry (registered)
//   count         : number of valid entries (0..2)
// A push and a pop in the same cycle are both honoured. A push into a full
// queue without a pop is dropped; the fetch issue rule never produces one.
// -----------------------------------------------------------------------------
module fetch_fifo
   import instr_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t slot0;
   fetch_entry_t slot1;
   logic         do_push;
   logic         do_pop;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
         count <= 2'd0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case (count)
            2'd0: begin
               if (do_push) begin
                  slot0 <= push_entry;
                  count <= 2'd1;
               end
            end
            2'd1: begin
               if (do_push && do_pop) begin
                  slot0 <= push_entry;
               end else if (do_push) begin
                  slot1 <= push_entry;
                  count <= 2'd2;
               end else if (do_pop) begin
                  count <= 2'd0;
               end
            end
            default: begin
               if (do_pop) begin
                  slot0 <= slot1;
                  if (do_push) begin
                     slot1 <= push_entry;
                  end else begin
                     count <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   assign head = slot0;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch unit. Owns the PC, issues word reads to an instruction
// memory with one-cycle registered read latency, buffers returned words in a
// two-entry queue and presents {pc, instr, fault} to decode.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem_rd         : read strobe to instruction memory
//   imem_addr       : word address {2'b00, pc[31:2]} (0 when not reading)
//   imem_instr      : read data, valid the cycle after imem_rd
//   if_valid        : entry presented to decode
//   if_ready        : decode accepts the presented entry
//   if_pc           : byte PC of the presented entry
//   if_instr        : instruction word (NOP for fault entries)
//   if_fault        : presented entry is a fetch fault
//   redirect_valid  : flush and restart fetching at redirect_pc
//   redirect_pc     : byte target of the redirect
// Handshake: an entry transfers in a cycle where if_valid and if_ready are
// both 1; if_valid is held low during a redirect so nothing transfers then.
// -----------------------------------------------------------------------------
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
   parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
   parameter logic [31:0] IMEM_LIMIT = DEF_IMEM_LIMIT
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_rd,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_fault,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   if_state_t    state;
   if_state_t    state_next;
   logic [31:0]  pc;
   logic [31:0]  tag;
   logic         inflight;
   logic         kill;

   fetch_entry_t head;
   fetch_entry_t push_entry;
   logic [1:0]   count;
   logic         push;
   logic         pop;
   logic         issue;
   logic         pc_ok;
   logic         room;

   assign pc_ok    = addr_legal(pc, IMEM_BASE, IMEM_LIMIT);
   assign if_valid = (count != 2'd0) && !redirect_valid;
   assign pop      = if_valid && if_ready;

   // Issue only if the queue can still hold everything already buffered,
   // the read in flight, and this new read, counting a same-cycle pop.
   assign room = (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      push       = 1'b0;
      push_entry = '{pc: tag, instr: imem_instr, fault: 1'b0};

      // Response for the read issued last cycle; dropped when it was
      // orphaned by a redirect.
      if (inflight && !kill) begin
         push = 1'b1;
      end

      case (state)
         IF_RUN: begin
            if (!pc_ok) begin
               state_next = IF_DRAIN;
            end else if (room) begin
               issue = 1'b1;
            end
         end
         IF_DRAIN: begin
            // Fault entry goes in only once everything older has left, so
            // decode sees it strictly after the good instructions.
            if ((count == 2'd0) && !inflight) begin
               push       = 1'b1;
               push_entry = '{pc: pc, instr: NOP_INSTR, fault: 1'b1};
               state_next = IF_HALT;
            end
         end
         IF_HALT: begin
            state_next = IF_HALT;
         end
         default: begin
            state_next = IF_RUN;
         end
      endcase

      if (redirect_valid) begin
         state_next = IF_RUN;
      end

      if (rst) begin
         issue = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IF_RUN;
         pc       <= RESET_PC;
         tag      <= '0;
         inflight <= 1'b0;
         kill     <= 1'b0;
      end else begin
         state    <= state_next;
         inflight <= issue;
         // With one-cycle read latency the only read that can outlive a
         // redirect is one issued in the redirect cycle itself.
         kill     <= redirect_valid && issue;
         if (issue) begin
            tag <= pc;
            pc  <= pc + 32'd4;
         end
         if (redirect_valid) begin
            pc <= redirect_pc;
         end
      end
   end

   fetch_fifo u_fifo (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count)
   );

   assign imem_rd   = issue;
   assign imem_addr = issue ? {2'b00, pc[31:2]} : 32'd0;

   assign if_pc    = head.pc;
   assign if_instr = head.instr;
   assign if_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        imem_rd;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_fault;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [512];

   // reference model state
   logic [64:0] exp_q [$];
   logic [31:0] iss_pc;
   int          iss_cnt;
   int          acc_cnt;
   logic        rst_edge = 1'b0;
   logic [64:0] cmp_e;

   instr_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .imem_rd        (imem_rd),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_fault       (if_fault),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rst_edge <= rst;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // ---------------- instruction memory ----------------
   always @(posedge clk) begin
      if (imem_rd && (imem_addr >= 32'h0040_0000) && (imem_addr < 32'h0040_0200))
         imem_instr <= mem[imem_addr[8:0]];
      else
         imem_instr <= $urandom;
   end

   // ---------------- helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic ref_legal(input logic [31:0] p);
      return (p[1:0] == 2'b00) && (p >= 32'h0100_0000) && (p <= 32'h0100_07FC);
   endfunction

   function automatic logic [31:0] mem_at(input logic [31:0] p);
      logic [31:0] off;
      off = p - 32'h0100_0000;
      return mem[off[10:2]];
   endfunction

   // Whole expected stream for a fetch starting at 'start': every legal
   // sequential word, then one fault entry at the first illegal address.
   task automatic model_start(input logic [31:0] start);
      logic [31:0] p;
      exp_q.delete();
      p = start;
      while (ref_legal(p)) begin
         exp_q.push_back({p, mem_at(p), 1'b0});
         p = p + 32'd4;
      end
      exp_q.push_back({p, 32'h0000_0013, 1'b1});
      iss_pc  = start;
      iss_cnt = 0;
      acc_cnt = 0;
   endtask

   // ---------------- scoreboard / compare process ----------------
   always @(negedge clk) begin
      if (rst) begin
         chk1("rd_in_reset", imem_rd, 1'b0);
         chk32("addr_in_reset", imem_addr, 32'd0);
         if (rst_edge) begin
            chk1("valid_in_reset", if_valid, 1'b0);
            chk32("pc_in_reset", if_pc, 32'd0);
            chk32("instr_in_reset", if_instr, 32'd0);
            chk1("fault_in_reset", if_fault, 1'b0);
         end
         model_start(32'h0100_0000);
      end else begin
         if (imem_rd) begin
            chk32("issue_addr", imem_addr, {2'b00, iss_pc[31:2]});
            chk1("issue_legal", ref_legal(iss_pc), 1'b1);
            iss_pc = iss_pc + 32'd4;
            iss_cnt++;
         end
         if (redirect_valid) begin
            chk1("valid_in_redirect", if_valid, 1'b0);
            model_start(redirect_pc);
         end else begin
            if (if_valid && if_ready) begin
               acc_cnt++;
               if (exp_q.size() == 0) begin
                  chk1("extra_entry", 1'b1, 1'b0);
               end else begin
                  cmp_e = exp_q.pop_front();
                  chk32("entry_pc", if_pc, cmp_e[64:33]);
                  chk32("entry_instr", if_instr, cmp_e[32:1]);
                  chk1("entry_fault", if_fault, cmp_e[0]);
               end
            end
            chk1("occupancy_le_2", (iss_cnt - acc_cnt) <= 2, 1'b1);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_redirect(input logic [31:0] target);
      cyc();
      redirect_valid = 1'b1;
      redirect_pc    = target;
      cyc();
      redirect_valid = 1'b0;
   endtask

   logic [31:0] hold_pc;
   logic [31:0] got_pc [3];
   logic [31:0] got_in [3];
   logic        got_ft [3];
   logic        found;
   int          got;
   int          r;

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      rst            = 1'b1;
      if_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      repeat (3) cyc();

      // startup: C0 issues RESET_PC, C2 presents it, one per cycle after
      rst = 1'b0;
      @(negedge clk);
      chk1("c0_rd", imem_rd, 1'b1);
      chk32("c0_addr", imem_addr, 32'h0040_0000);
      chk1("c0_valid", if_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk1("c1_valid", if_valid, 1'b0);
      for (int k = 0; k < 12; k++) begin
         cyc();
         @(negedge clk);
         chk1("stream_valid", if_valid, 1'b1);
         chk32("stream_pc", if_pc, 32'h0100_0000 + 32'(4 * k));
         chk1("stream_rd", imem_rd, 1'b1);
      end

      // stall decode for 5 cycles
      cyc();
      if_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         if (s == 0) hold_pc = if_pc;
         chk1("stall_valid", if_valid, 1'b1);
         chk1("stall_rd", imem_rd, 1'b0);
         chk32("stall_hold_pc", if_pc, hold_pc);
         if (s < 4) cyc();
      end
      cyc();
      if_ready = 1'b1;
      repeat (4) cyc();

      // redirect with a read in flight
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0100_0100;
      @(negedge clk);
      chk1("redir_n_valid", if_valid, 1'b0);
      cyc();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk1("redir_n1_rd", imem_rd, 1'b1);
      chk32("redir_n1_addr", imem_addr, 32'h0040_0040);
      chk1("redir_n1_valid", if_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk1("redir_n2_valid", if_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk1("redir_n3_valid", if_valid, 1'b1);
      chk32("redir_n3_pc", if_pc, 32'h0100_0100);
      chk1("redir_n3_fault", if_fault, 1'b0);
      repeat (3) cyc();

      // randomized traffic: backpressure, redirects, reset pulses
      for (int it = 0; it < 400; it++) begin
         cyc();
         rst            = 1'b0;
         redirect_valid = 1'b0;
         if_ready       = ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 99));
         if (r < 4) begin
            redirect_valid = 1'b1;
            case ($urandom_range(0, 4))
               0: redirect_pc = 32'h0100_0000 + 32'($urandom_range(0, 511)) * 32'd4;
               1: redirect_pc = 32'h0100_07E0 + 32'($urandom_range(0, 7)) * 32'd4;
               2: redirect_pc = 32'h0100_0000 + 32'($urandom_range(0, 2047));
               3: redirect_pc = 32'h0100_0000 - 32'($urandom_range(1, 4)) * 32'd4;
               default: redirect_pc = 32'h0100_0800 + 32'($urandom_range(0, 3)) * 32'd4;
            endcase
         end else if (r == 4) begin
            rst = 1'b1;
         end
      end
      cyc();
      rst            = 1'b0;
      redirect_valid = 1'b0;
      if_ready       = 1'b1;

      // misaligned redirect: one fault entry, then silence
      do_redirect(32'h0100_0102);
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
         @(negedge clk);
         chk1("mis_no_rd", imem_rd, 1'b0);
         if (if_valid) begin
            found = 1'b1;
            chk32("mis_pc", if_pc, 32'h0100_0102);
            chk32("mis_instr", if_instr, 32'h0000_0013);
            chk1("mis_fault", if_fault, 1'b1);
         end else begin
            cyc();
         end
      end
      chk1("mis_seen", found, 1'b1);
      for (int w = 0; w < 8; w++) begin
         cyc();
         @(negedge clk);
         chk1("halt_valid", if_valid, 1'b0);
         chk1("halt_rd", imem_rd, 1'b0);
      end

      // sequential run off the end of memory
      do_redirect(32'h0100_07F8);
      got = 0;
      for (int w = 0; w < 20 && got < 3; w++) begin
         @(negedge clk);
         if (if_valid && if_ready) begin
            got_pc[got] = if_pc;
            got_in[got] = if_instr;
            got_ft[got] = if_fault;
            got++;
         end
         cyc();
      end
      chk32("wrap_count", 32'(got), 32'd3);
      if (got == 3) begin
         chk32("wrap_pc0", got_pc[0], 32'h0100_07F8);
         chk32("wrap_in0", got_in[0], mem[510]);
         chk1("wrap_ft0", got_ft[0], 1'b0);
         chk32("wrap_pc1", got_pc[1], 32'h0100_07FC);
         chk32("wrap_in1", got_in[1], mem[511]);
         chk1("wrap_ft1", got_ft[1], 1'b0);
         chk32("wrap_pc2", got_pc[2], 32'h0100_0800);
         chk32("wrap_in2", got_in[2], 32'h0000_0013);
         chk1("wrap_ft2", got_ft[2], 1'b1);
      end

      // one-cycle reset pulse mid-stream
      do_redirect(32'h0100_0000);
      repeat (6) cyc();
      rst = 1'b1;
      @(negedge clk);
      chk1("pulse_rd", imem_rd, 1'b0);
      chk32("pulse_addr", imem_addr, 32'd0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk1("post_c0_valid", if_valid, 1'b0);
      chk32("post_c0_pc", if_pc, 32'd0);
      chk32("post_c0_instr", if_instr, 32'd0);
      chk1("post_c0_fault", if_fault, 1'b0);
      chk1("post_c0_rd", imem_rd, 1'b1);
      chk32("post_c0_addr", imem_addr, 32'h0040_0000);
      cyc();
      @(negedge clk);
      chk1("post_c1_valid", if_valid, 1'b0);
      cyc();
      @(negedge clk);
      chk1("post_c2_valid", if_valid, 1'b1);
      chk32("post_c2_pc", if_pc, 32'h0100_0000);
      chk32("post_c2_instr", if_instr, mem[0]);
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
